// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input valid/ready mux with an internal arbiter, either
// round-robin or fixed priority. The winning word goes into a single-entry
// output register that has its own valid/ready handshake.
module rr_arb_mux #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = 0,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] w_ch [N];
  logic [SELW-1:0]  w_base;
  logic [SELW-1:0]  w_scan;
  logic [SELW-1:0]  w_gnt_idx;
  logic             w_gnt_vld;
  logic [N-1:0]     w_gnt_oh;
  logic             w_can_accept;
  logic             w_xfer;

  logic [SELW-1:0]  r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_src;
  logic             r_out_valid;

  // Unpack the flat input bus into per-channel words
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign w_ch[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Fixed priority is round-robin with the search base pinned at channel 0
  assign w_base = (MODE == 0) ? r_ptr : '0;

  // Search base, base+1, ... (mod N) for the first valid requester
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int k = 0; k < N; k++) begin
      w_scan = w_base + SELW'(k);
      if (!w_gnt_vld && in_valid[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  assign w_gnt_oh     = w_gnt_vld ? (N'(1) << w_gnt_idx) : '0;
  assign w_can_accept = !r_out_valid || out_ready;
  assign w_xfer       = w_gnt_vld && w_can_accept && !reset;
  assign in_ready     = w_gnt_oh & {N{w_can_accept && !reset}};

  // Output register: load on transfer, clear valid on drain, hold on stall
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch[w_gnt_idx];
      r_out_src   <= w_gnt_idx;
      if (MODE == 0) begin
        r_ptr <= w_gnt_idx + SELW'(1);
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus random traffic, run on a
// round-robin instance and a fixed-priority instance, both checked against
// a transaction-level reference model.
module tb_rr_arb_mux;

  localparam int unsigned W = 64;
  localparam int unsigned N = 4;

  logic           clk;
  logic           reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic           out_ready;

  logic [N-1:0]   d_ready [2];
  logic [W-1:0]   d_data  [2];
  logic [1:0]     d_src   [2];
  logic           d_valid [2];

  // Reference model state: index 0 = round-robin, 1 = fixed priority
  logic           m_ov  [2];
  logic [W-1:0]   m_od  [2];
  logic [1:0]     m_os  [2];
  int             m_ptr [2];

  int n_checks = 0;
  int n_errors = 0;

  rr_arb_mux #(.WIDTH(W), .N(N), .MODE(0)) u_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(d_ready[0]), .out_data(d_data[0]), .out_src(d_src[0]),
    .out_valid(d_valid[0]), .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(W), .N(N), .MODE(1)) u_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(d_ready[1]), .out_data(d_data[1]), .out_src(d_src[1]),
    .out_valid(d_valid[1]), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  // Winner for instance d: first valid channel starting at its pointer
  function automatic int model_grant(int d, logic [N-1:0] v);
    int base;
    base = (d == 0) ? m_ptr[d] : 0;
    for (int k = 0; k < N; k++)
      if (v[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready(int d);
    int g;
    g = model_grant(d, in_valid);
    if (reset || g < 0 || !(!m_ov[d] || out_ready)) return '0;
    return N'(1) << g;
  endfunction

  // Advance the model using the inputs in force now, then cross one edge
  task automatic tick();
    int g;
    for (int d = 0; d < 2; d++) begin
      g = model_grant(d, in_valid);
      if (reset) begin
        m_ov[d] = 1'b0; m_od[d] = '0; m_os[d] = '0; m_ptr[d] = 0;
      end else if (g >= 0 && (!m_ov[d] || out_ready)) begin
        m_ov[d] = 1'b1;
        m_od[d] = in_data[g*W +: W];
        m_os[d] = 2'(g);
        if (d == 0) m_ptr[d] = (g + 1) % N;
      end else if (out_ready) begin
        m_ov[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern(logic [W-1:0] base);
    for (int i = 0; i < N; i++) in_data[i*W +: W] = base + W'(i);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = '0; out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    set_pattern(64'h10);
    tick();
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        n_checks++; if (d_ready[d] !== 4'b0000) begin n_errors++; $display("FAIL rst_ready d=%0d got=%b exp=0000", d, d_ready[d]); end
        n_checks++; if (d_valid[d] !== 1'b0) begin n_errors++; $display("FAIL rst_valid d=%0d got=%b exp=0", d, d_valid[d]); end
        n_checks++; if (d_data[d] !== 64'h0 || d_src[d] !== 2'd0) begin n_errors++; $display("FAIL rst_data d=%0d got=%h/%0d exp=0/0", d, d_data[d], d_src[d]); end
      end
      tick();
    end
    reset = 1'b0;
    #1;
    n_checks++; if (d_ready[0] !== 4'b0001) begin n_errors++; $display("FAIL rst_first_grant got=%b exp=0001", d_ready[0]); end
    tick();
    n_checks++; if (d_valid[0] !== 1'b1 || d_data[0] !== 64'h10 || d_src[0] !== 2'd0) begin
      n_errors++; $display("FAIL rst_first_word got=%b/%h/%0d exp=1/10/0", d_valid[0], d_data[0], d_src[0]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] e;
    do_reset();
    set_pattern(64'h10); in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (d_ready[0] !== (4'b0001 << (c % 4))) begin n_errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, d_ready[0], 4'b0001 << (c % 4)); end
      if (c > 0) begin
        e = 2'((c - 1) % 4);
        n_checks++; if (d_valid[0] !== 1'b1 || d_src[0] !== e || d_data[0] !== 64'h10 + W'(e)) begin
          n_errors++; $display("FAIL rr_seq c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, d_valid[0], d_src[0], d_data[0], e, 64'h10 + W'(e)); end
        n_checks++; if (d_src[1] !== 2'd0) begin n_errors++; $display("FAIL rr_fp_src c=%0d got=%0d exp=0", c, d_src[1]); end
      end
      tick();
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_pattern(64'h20); in_valid = 4'b1010; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (d_ready[1] !== 4'b0010) begin n_errors++; $display("FAIL fp_ready c=%0d got=%b exp=0010", c, d_ready[1]); end
      if (c > 0) begin
        n_checks++; if (d_src[1] !== 2'd1 || d_data[1] !== 64'h21) begin n_errors++; $display("FAIL fp_src c=%0d got=%0d/%h exp=1/21", c, d_src[1], d_data[1]); end
      end
      tick();
    end
    in_valid = 4'b1000;
    #1;
    n_checks++; if (d_ready[1] !== 4'b1000) begin n_errors++; $display("FAIL fp_ch3_ready got=%b exp=1000", d_ready[1]); end
    tick();
    n_checks++; if (d_src[1] !== 2'd3 || d_data[1] !== 64'h23) begin n_errors++; $display("FAIL fp_ch3_word got=%0d/%h exp=3/23", d_src[1], d_data[1]); end
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_pattern(64'h0);
    in_data[0 +: W] = 64'hAA; in_data[2*W +: W] = 64'h22;
    in_valid = 4'b0001; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 4'b0100; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (d_ready[0] !== 4'b0000) begin n_errors++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, d_ready[0]); end
      n_checks++; if (d_valid[0] !== 1'b1 || d_data[0] !== 64'hAA || d_src[0] !== 2'd0) begin
        n_errors++; $display("FAIL bp_hold c=%0d got=%b/%h/%0d exp=1/aa/0", c, d_valid[0], d_data[0], d_src[0]); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (d_ready[0] !== 4'b0100) begin n_errors++; $display("FAIL bp_release got=%b exp=0100", d_ready[0]); end
    tick();
    n_checks++; if (d_valid[0] !== 1'b1 || d_data[0] !== 64'h22 || d_src[0] !== 2'd2) begin
      n_errors++; $display("FAIL bp_load got=%b/%h/%0d exp=1/22/2", d_valid[0], d_data[0], d_src[0]); end
  endtask

  task automatic test_drain();
    do_reset();
    set_pattern(64'h10); in_valid = 4'b0010; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 4'b0000;
    #1;
    n_checks++; if (d_valid[0] !== 1'b1 || d_data[0] !== 64'h11) begin n_errors++; $display("FAIL dr_word got=%b/%h exp=1/11", d_valid[0], d_data[0]); end
    tick();
    n_checks++; if (d_valid[0] !== 1'b0 || d_data[0] !== 64'h11 || d_src[0] !== 2'd1) begin
      n_errors++; $display("FAIL dr_empty got=%b/%h/%0d exp=0/11/1", d_valid[0], d_data[0], d_src[0]); end
    tick();
    in_valid = 4'b0100;
    #1;
    n_checks++; if (d_ready[0] !== 4'b0100) begin n_errors++; $display("FAIL dr_next_ready got=%b exp=0100", d_ready[0]); end
    tick();
    n_checks++; if (d_valid[0] !== 1'b1 || d_src[0] !== 2'd2 || d_data[0] !== 64'h12) begin
      n_errors++; $display("FAIL dr_next_word got=%b/%0d/%h exp=1/2/12", d_valid[0], d_src[0], d_data[0]); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    set_pattern(64'h30); in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 4'b0001;
    #1;
    n_checks++; if (d_ready[0] !== 4'b0001) begin n_errors++; $display("FAIL wr_ch0 got=%b exp=0001", d_ready[0]); end
    tick();
    in_valid = 4'b1111;
    #1;
    n_checks++; if (d_ready[0] !== 4'b0010) begin n_errors++; $display("FAIL wr_ptr1 got=%b exp=0010", d_ready[0]); end
    out_ready = 1'b0;
    #1;
    n_checks++; if (d_ready[0] !== 4'b0000) begin n_errors++; $display("FAIL wr_stall got=%b exp=0000", d_ready[0]); end
    tick();
    tick();
    n_checks++; if (d_valid[0] !== 1'b1 || d_src[0] !== 2'd0 || d_data[0] !== 64'h30) begin
      n_errors++; $display("FAIL wr_hold got=%b/%0d/%h exp=1/0/30", d_valid[0], d_src[0], d_data[0]); end
    reset = 1'b1;
    #1;
    n_checks++; if (d_ready[0] !== 4'b0000) begin n_errors++; $display("FAIL wr_rst_ready got=%b exp=0000", d_ready[0]); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (d_valid[0] !== 1'b0) begin n_errors++; $display("FAIL wr_rst_valid got=%b exp=0", d_valid[0]); end
    n_checks++; if (d_ready[0] !== 4'b0001) begin n_errors++; $display("FAIL wr_rst_ptr got=%b exp=0001", d_ready[0]); end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = {$urandom, $urandom};
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 49) == 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        er = model_ready(d);
        n_checks++; if (d_ready[d] !== er) begin n_errors++; $display("FAIL rnd_ready d=%0d c=%0d got=%b exp=%b", d, c, d_ready[d], er); end
        n_checks++; if (d_valid[d] !== m_ov[d]) begin n_errors++; $display("FAIL rnd_valid d=%0d c=%0d got=%b exp=%b", d, c, d_valid[d], m_ov[d]); end
        n_checks++; if (d_data[d] !== m_od[d]) begin n_errors++; $display("FAIL rnd_data d=%0d c=%0d got=%h exp=%h", d, c, d_data[d], m_od[d]); end
        n_checks++; if (d_src[d] !== m_os[d]) begin n_errors++; $display("FAIL rnd_src d=%0d c=%0d got=%0d exp=%0d", d, c, d_src[d], m_os[d]); end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = '0;
    for (int d = 0; d < 2; d++) begin
      m_ov[d] = 1'b0; m_od[d] = '0; m_os[d] = '0; m_ptr[d] = 0;
    end
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_back_pressure();
    test_drain();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised N-input, WIDTH-bit multiplexer. Input channel selection is made by an internal arbiter, not by an external select line. Each input channel uses a valid/ready handshake. The winning channel's word is captured into a single-entry output register with its own valid/ready handshake. The block merges multiple requesters (e.g. fetch/load/store paths) onto one shared datapath port in the CPU.

Parameters:
WIDTH, 64, data bits per channel (≥1)
N, 4, number of input channels (power of two, ≥2)
MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
SELW, $clog2(N), derived width of channel index; not overridden

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  channel i has a word to offer
in_ready  output  N  channel i's word is accepted this cycle (one-hot or zero)
out_data  output  WIDTH  registered winning word
out_src  output  SELW  index of channel that supplied out_data
out_valid  output  1  out_data/out_src hold a word
out_ready  input  1  downstream accepts the output word this cycle

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values (reset high at a rising edge):
  - out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0.
  - While reset is high, in_ready=0 (combinational override).
  - Reset mid-transfer discards the held word; no handshake completes in a cycle where reset is high.
- can_accept = !out_valid | out_ready (register empty, or being drained this cycle).
- Grant (combinational):
  - MODE 0: first i with in_valid[i]=1, searching ptr, ptr+1, … mod N.
  - MODE 1: lowest i with in_valid[i]=1.
  - No valid input: no grant.
- in_ready[i] = grant[i] & can_accept & !reset. At most one bit set. in_ready never depends on in_valid of the same channel except through the grant.
- Input transfer = in_valid[g] & in_ready[g]. On the next edge: out_data <= in_data[g], out_src <= g, out_valid <= 1.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 word/cycle when out_ready is held high.
- Drain without refill (out_valid & out_ready and no input transfer): out_valid <= 0. out_data/out_src retain their last value.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, out_valid stays 1, and there is no bubble.
- Stall (out_valid & !out_ready):
  - out_data, out_src and out_valid are held stable.
  - All in_ready=0.
- Pointer (MODE 0 only):
  - On an input transfer, ptr <= (g+1) mod N. Wrap from N-1 to 0 is natural.
  - ptr is unchanged when there is no transfer, including stalled cycles with valid requests.
- MODE 1: ptr is unused and stays 0.
- Fairness (MODE 0): with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… Every requester is served within N accepted transfers.
- in_valid deasserting without a handshake is permitted. Arbitration re-evaluates every cycle, so the grant is not sticky.

Test Plan:
- Reset: drive in_valid=all ones and hold reset for 2 cycles -> in_ready=0 and out_valid=0 throughout; after release, first grant to ch0, and out_data=in_data[0] one cycle later with out_src=0.
- Round-robin: N=4, MODE 0, all valid with in_data[i]=0x10+i, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_data 0x10,0x11,0x12,0x13,0x10, out_valid continuously 1.
- Fixed priority: MODE 1, in_valid=4'b1010 -> only ch1 granted every cycle, out_src=1 repeatedly; ch3 is served only once in_valid[1] drops.
- Back-pressure: out_valid=1 holding 0xAA, out_ready=0 for 3 cycles while ch2 is valid -> in_ready=0, out_data stays 0xAA; on the cycle out_ready=1, in_ready[2]=1, and next cycle out_data=in_data[2].
- Drain/empty: single word accepted, then in_valid=0 and out_ready=1 -> out_valid falls after one cycle; ptr unchanged, so the next lone request on ch(g+1) is granted immediately.
- Sparse/wrap: ptr=3 and only ch0 valid -> ch0 granted and ptr becomes 1; then assert reset mid-stall -> out_valid=0 and ptr=0 on the following cycle.
